// File: rtl/pair_triple_pkg.sv
// Shared definitions for the pair/triple (2-of-3 majority) self-test checker.
package pair_triple_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Only the three pattern lines toward the detector are driven.
   localparam logic [7:0] UIO_OE_MASK = 8'b0000_0111;

   // Golden 2-of-3 majority the detector result is compared against.
   function automatic logic maj3(input logic [2:0] p);
      return (p[0] & p[1]) | (p[2] & (p[0] | p[1]));
   endfunction

   // Hex seven-segment patterns, bit0 = segment a, active-high.
   localparam logic [6:0] SEG7_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex to seven-segment decoder.
module seg7_hex_decoder
   import pair_triple_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] segments
);

   assign segments = SEG7_TABLE[value];

endmodule

// File: rtl/pair_triple_stim_checker.sv
// Sweeps all 3-bit patterns to a majority detector, checks its answers
// against a golden model and shows the mismatch count on a 7-seg display.
module pair_triple_stim_checker
   import pair_triple_pkg::*;
#(
   parameter int MAX_COUNT = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(MAX_COUNT - 1);

   state_t          state, state_nxt;
   logic [2:0]      pattern, pattern_nxt;
   logic [3:0]      err, err_nxt;
   logic [PW-1:0]   prescaler, prescaler_nxt;
   logic            start_q;

   logic            start_ev;
   logic            cont_mode;
   logic            pause;
   logic            tick;
   logic [6:0]      segments;

   assign start_ev  = ui_in[0] & ~start_q;
   assign cont_mode = ui_in[1];
   assign pause     = ui_in[2];
   assign tick      = (prescaler == PRESC_LAST) && !pause;

   // Inputs that the interface defines but this block does not consume.
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in[7:4], uio_in[2:0]};

   // State, sweep and error registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!rst_n) begin
         state     <= ST_IDLE;
         pattern   <= 3'd0;
         err       <= 4'd0;
         prescaler <= '0;
         start_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pattern   <= pattern_nxt;
         err       <= err_nxt;
         prescaler <= prescaler_nxt;
         start_q   <= ui_in[0];
      end
   end

   // Next-state logic: sweep sequencing, sampling and restart handling.
   always_comb begin
      // NOTE: defaults first so every path assigns every output, no latches.
      state_nxt     = state;
      pattern_nxt   = pattern;
      err_nxt       = err;
      prescaler_nxt = prescaler;

      unique case (state)
         ST_IDLE: begin
            if (start_ev) begin
               state_nxt     = ST_DRIVE;
               pattern_nxt   = 3'd0;
               err_nxt       = 4'd0;
               prescaler_nxt = '0;
            end
         end
         ST_DRIVE: begin
            if (tick) begin
               if (uio_in[3] != maj3(pattern) && err != 4'hF)
                  err_nxt = err + 4'd1;
               prescaler_nxt = '0;
               if (pattern == 3'd7)
                  state_nxt = ST_DONE;
               else
                  pattern_nxt = pattern + 3'd1;
            end else if (!pause) begin
               prescaler_nxt = prescaler + 1'b1;
            end
         end
         ST_DONE: begin
            // A start event and a continuous-mode tick collapse into one restart.
            if (start_ev || (cont_mode && tick)) begin
               state_nxt     = ST_DRIVE;
               pattern_nxt   = 3'd0;
               err_nxt       = 4'd0;
               prescaler_nxt = '0;
            end else if (cont_mode && !pause) begin
               prescaler_nxt = prescaler + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   seg7_hex_decoder u_seg (
      .value    (err),
      .segments (segments)
   );

   // Output mapping: pattern lines, pass flag and error display.
   always_comb begin
      uio_out = 8'h00;
      if (state == ST_DRIVE)
         uio_out[2:0] = pattern;
      else if (state == ST_DONE)
         uio_out[2:0] = 3'd7;
      uo_out = {(state == ST_DONE) && (err == 4'd0), segments};
      uio_oe = UIO_OE_MASK;
   end

endmodule

// File: tb/tb_pair_triple_stim_checker.sv
// Directed self-checking bench for pair_triple_stim_checker (MAX_COUNT=4).
module tb_pair_triple_stim_checker;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp = 0;
   int n_err = 0;

   // Detector model: 0 = correct, 1 = stuck-at-0, 2 = inverted.
   int         det_mode;
   logic [7:0] maj_tab;
   logic       det;

   pair_triple_stim_checker #(.MAX_COUNT(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (1'b1),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Majority of patterns 0..7 by hand: true for 3,5,6,7.
   always_comb begin
      maj_tab = 8'b1110_1000;
      case (det_mode)
         1:       det = 1'b0;
         2:       det = ~maj_tab[uio_out[2:0]];
         default: det = maj_tab[uio_out[2:0]];
      endcase
      uio_in = {4'b0000, det, 3'b000};
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulse start, follow the sweep cycle by cycle, check the final display.
   task automatic do_sweep(input int pause_cycles, input logic hold_start,
                           input logic [7:0] exp_uo);
      int hold;
      ui_in[0] = 1'b1;
      @(negedge clk);
      if (!hold_start) ui_in[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         hold = 4 + ((k == 2) ? pause_cycles : 0);
         for (int h = 0; h < hold; h++) begin
            check($sformatf("pattern%0d_h%0d", k, h), uio_out, 8'(k));
            if (k == 2 && pause_cycles > 0 && h == 1) ui_in[2] = 1'b1;
            if (k == 2 && pause_cycles > 0 && h == 1 + pause_cycles) ui_in[2] = 1'b0;
            @(negedge clk);
         end
      end
      check("done_pattern", uio_out, 8'h07);
      check("done_display", uo_out, exp_uo);
      check("uio_oe", uio_oe, 8'h07);
   endtask

   initial begin
      det_mode = 0;
      ui_in    = 8'h00;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_uio_out", uio_out, 8'h00);
      check("reset_uo_out", uo_out, 8'h3F);
      check("reset_uio_oe", uio_oe, 8'h07);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_uio_out", uio_out, 8'h00);

      // Correct detector: pass flag set, display "0".
      do_sweep(0, 1'b0, 8'hBF);
      repeat (5) @(negedge clk);
      check("done_hold_pattern", uio_out, 8'h07);
      check("done_hold_display", uo_out, 8'hBF);

      // Stuck-at-0: mismatches at 3,5,6,7, restarted from DONE.
      det_mode = 1;
      do_sweep(0, 1'b0, 8'h66);

      // Inverted: all eight wrong, twice; count is cleared on restart.
      det_mode = 2;
      do_sweep(0, 1'b0, 8'h7F);
      do_sweep(0, 1'b0, 8'h7F);

      // Pause during pattern 2 stretches it to 14 cycles, same result.
      det_mode = 1;
      do_sweep(10, 1'b0, 8'h66);

      // Continuous mode with start held high: one start event only,
      // then restart exactly 4 cycles after DONE entry.
      det_mode = 0;
      ui_in[1] = 1'b1;
      do_sweep(0, 1'b1, 8'hBF);
      for (int h = 1; h < 4; h++) begin
         @(negedge clk);
         check($sformatf("cont_idle_%0d", h), uo_out, 8'hBF);
      end
      @(negedge clk);
      check("cont_restart_pattern", uio_out, 8'h00);
      check("cont_restart_display", uo_out, 8'h3F);
      ui_in[1] = 1'b0;
      repeat (4) @(negedge clk);
      check("cont_pattern1", uio_out, 8'h01);

      // Reset in the middle of pattern 5.
      repeat (16 + 2) @(negedge clk);
      check("pre_reset_pattern", uio_out, 8'h05);
      ui_in[0] = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset_uio_out", uio_out, 8'h00);
      check("midreset_uo_out", uo_out, 8'h3F);
      check("midreset_uio_oe", uio_oe, 8'h07);
      repeat (6) @(negedge clk);
      check("post_reset_idle", uio_out, 8'h00);
      check("post_reset_display", uo_out, 8'h3F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pair_triple_stim_checker.md
Name: pair_triple_stim_checker

Overview:
Driving end of the pair/triple (2-of-3 majority) detector interface.
- Sweeps all eight 3-bit input patterns out on uio_out[2:0] at a prescaled rate.
- Samples the detector's returned result on uio_in[3] and compares it against an internal golden majority.
- Shows the mismatch count on the seven-segment display.
- Used as an on-chip self-test companion to the detector.

Parameters:
MAX_COUNT, 10_000_000, clk cycles each pattern is held before its result is sampled. Must be >= 2; benches use 4.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  design enable; unused, ignored
ui_in  input  8  [0] start, [1] continuous mode, [2] pause, [7:3] unused
uo_out  output  8  [6:0] seven-seg segments a..g (active-high) of error count; [7] pass flag
uio_in  input  8  [3] detector result; all other bits ignored
uio_out  output  8  [2:0] pattern driven to detector; [7:3] = 0
uio_oe  output  8  constant 8'b0000_0111

Behaviour:
- One clock; reset is synchronous and active-low on rst_n.
- When rst_n=0 at a clk edge, all of the following are set regardless of other inputs:
  - state=IDLE, pattern=0, err=0, prescaler=0, start_q=0.
  - uio_out=0, uo_out[7]=0.
  - uo_out[6:0] = segments for digit "0" (7'b0111111, bit0=a).
- Start detection:
  - start_q registers ui_in[0] every cycle.
  - A start event is ui_in[0]=1 && start_q=0.
  - Start events are ignored outside IDLE and DONE.
- States: IDLE, DRIVE, DONE.
  - IDLE -> DRIVE on a start event. On that edge: pattern<=0, err<=0, prescaler<=0.
  - DRIVE:
    - uio_out[2:0]=pattern.
    - The prescaler increments each cycle unless ui_in[2]=1; pause freezes it and holds everything else.
    - Tick: prescaler==MAX_COUNT-1 with pause=0. Each pattern is therefore held exactly MAX_COUNT unpaused cycles.
    - On tick:
      - Compare uio_in[3] with maj(pattern) = (p0&p1)|(p2&(p0|p1)).
      - On mismatch, err<=err+1, saturating at 15.
      - prescaler<=0.
      - If pattern==7: -> DONE. Otherwise pattern<=pattern+1 and stay in DRIVE.
  - DONE:
    - uio_out[2:0] holds 7.
    - uo_out[7]=1 iff err==0. uo_out[7]=0 in every other state.
    - If ui_in[1]=1: the prescaler runs. On tick, go to DRIVE with pattern=0, err=0, prescaler=0. This inserts one idle period between sweeps.
    - A start event in DONE restarts immediately, exactly as from IDLE.
    - If ui_in[1]=0 and no start event: stay in DONE indefinitely.
- Timing from a start event accepted at edge N:
  - Pattern 0 is visible from N+1.
  - Its sample is taken at edge N+MAX_COUNT (with no pause).
  - Pattern k is sampled at edge N+(k+1)*MAX_COUNT.
  - DONE is entered at edge N+8*MAX_COUNT.
- Display:
  - uo_out[6:0] = hex seven-seg decode of err (0-F), combinational from the err register.
  - The display updates the cycle after an increment.
- Widths:
  - prescaler is $clog2(MAX_COUNT) bits.
  - pattern is 3 bits; it never wraps, because the sweep terminates at 7.
  - err is 4 bits, saturating.
- Simultaneous events:
  - Pause asserted on a would-be tick cycle suppresses the tick.
  - A start event together with a continuous-mode tick in DONE is a single restart.
- Reset mid-sweep aborts the sweep with no sample recorded.

Decomposition:
- Shared package pair_triple_pkg holds:
  - state encoding (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2)
  - UIO_OE_MASK = 8'b0000_0111
  - the maj3 golden function
  - the 16-entry seven-seg constant table
- One sub-module: seg7_hex_decoder (4-bit in, 7-bit out, purely combinational).

Test Plan:
- Correct detector: loop uio_out[2:0] to a majority model on uio_in[3], MAX_COUNT=4, pulse start -> patterns 0..7 each held 4 cycles; DONE at 32 cycles after start; uo_out[7]=1; uo_out[6:0]=7'b0111111.
- Stuck-at-0 result: uio_in[3]=0 -> 4 mismatches (patterns 3,5,6,7); seg shows "4" (7'b1100110); uo_out[7]=0.
- Inverted detector: return ~maj -> err=8 ("8", 7'b1111111). Run 2 sweeps without reset, err=0 at each restart -> second sweep also ends with err=8 (the count is not carried over).
- Pause: hold ui_in[2]=1 for 10 cycles during pattern 2 -> pattern 2 held 14 cycles total; final err unchanged versus the unpaused run.
- Continuous mode: ui_in[1]=1 after DONE -> restart pattern 0 exactly MAX_COUNT cycles after DONE entry. Holding start high continuously -> only one start event.
- Reset mid-sweep: rst_n=0 for one edge at pattern 5 -> next cycle state IDLE, uio_out=0, display "0", uio_oe=8'h07 throughout.
